// File: rtl/unidad_control_alu.sv
// Sequencing and register-file stage in front of a 4-bit ALU: accepts one
// instruction per three cycles, feeds the ALU, writes back and counts retirements.
module unidad_control_alu #(
  parameter logic [3:0] P_OP_LDI = 4'b1111
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [11:0] ivPalabra,
  input  logic        iValido,
  output logic        oListo,
  output logic [3:0]  ovOpcode,
  output logic [3:0]  ovOperandoA,
  output logic [3:0]  ovOperandoB,
  input  logic [3:0]  ivResultado,
  input  logic [3:0]  ivFlagsAlu,
  output logic [3:0]  ovFlags,
  output logic        oHecho,
  output logic        oError,
  input  logic [1:0]  ivSelLectura,
  output logic [3:0]  ovLectura,
  output logic [7:0]  ovContador
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EJECUTA = 2'd1,
    ESCRIBE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  regs [4];
  logic [3:0]  op_p1;
  logic [1:0]  rd_p1;
  logic [3:0]  imm_p1;
  logic        reservado;

  // ALU opcodes occupy 0..10; 11..14 are reserved, 15 is load-immediate
  assign reservado = (op_p1 > 4'd10) && (op_p1 != P_OP_LDI);
  assign ovLectura = regs[ivSelLectura];

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    oListo     = 1'b0;
    oHecho     = 1'b0;
    oError     = 1'b0;
    case (state)
      IDLE: begin
        oListo = 1'b1;
        if (iValido) state_next = EJECUTA;
      end
      EJECUTA: begin
        state_next = ESCRIBE;
      end
      ESCRIBE: begin
        oHecho     = 1'b1;
        oError     = reservado;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage p0 -> p1: capture the word and read both operands at acceptance
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ovOpcode    <= 4'd0;
      ovOperandoA <= 4'd0;
      ovOperandoB <= 4'd0;
      op_p1       <= 4'd0;
      rd_p1       <= 2'd0;
      imm_p1      <= 4'd0;
    end else if (state == IDLE && iValido) begin
      ovOpcode    <= ivPalabra[11:8];
      ovOperandoA <= regs[ivPalabra[5:4]];
      ovOperandoB <= regs[ivPalabra[1:0]];
      op_p1       <= ivPalabra[11:8];
      rd_p1       <= ivPalabra[7:6];
      imm_p1      <= ivPalabra[3:0];
    end
  end

  // Stage p1 -> p2: writeback and flag update at the end of EJECUTA
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= 4'd0;
      ovFlags <= 4'd0;
    end else if (state == EJECUTA) begin
      if (op_p1 == P_OP_LDI) begin
        regs[rd_p1] <= imm_p1;
      end else if (op_p1 <= 4'd10) begin
        regs[rd_p1] <= ivResultado;
        ovFlags     <= ivFlagsAlu;
      end
    end
  end

  // Retirement count advances as ESCRIBE completes, so an aborted instruction is never counted
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ovContador <= 8'd0;
    end else if (state == ESCRIBE) begin
      ovContador <= ovContador + 8'd1;
    end
  end

endmodule

// File: tb/tb_unidad_control_alu.sv
// Bench for unidad_control_alu: hand-computed vector table, hold/abort/wrap
// sequences and random instructions against an instruction-level model.
module tb_unidad_control_alu;

  logic        iClk;
  logic        iRst_n;
  logic [11:0] ivPalabra;
  logic        iValido;
  logic        oListo;
  logic [3:0]  ovOpcode;
  logic [3:0]  ovOperandoA;
  logic [3:0]  ovOperandoB;
  logic [3:0]  ivResultado;
  logic [3:0]  ivFlagsAlu;
  logic [3:0]  ovFlags;
  logic        oHecho;
  logic        oError;
  logic [1:0]  ivSelLectura;
  logic [3:0]  ovLectura;
  logic [7:0]  ovContador;

  int checks   = 0;
  int failures = 0;

  unidad_control_alu dut (
    .iClk(iClk), .iRst_n(iRst_n), .ivPalabra(ivPalabra), .iValido(iValido),
    .oListo(oListo), .ovOpcode(ovOpcode), .ovOperandoA(ovOperandoA),
    .ovOperandoB(ovOperandoB), .ivResultado(ivResultado), .ivFlagsAlu(ivFlagsAlu),
    .ovFlags(ovFlags), .oHecho(oHecho), .oError(oError),
    .ivSelLectura(ivSelLectura), .ovLectura(ovLectura), .ovContador(ovContador)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Behavioural 4-bit ALU: returns {result, Z, N, C, V}
  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic c, v;
    s = 5'd0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin s = a + b; c = s[4]; v = (a[3] == b[3]) && (s[3] != a[3]); end
      4'd1: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; c = s[4]; v = (a[3] != b[3]) && (s[3] != a[3]); end
      4'd2: s = {1'b0, a & b};
      4'd3: s = {1'b0, a | b};
      4'd4: s = {1'b0, a ^ b};
      4'd5: s = {1'b0, ~a};
      4'd6: begin s = {1'b0, a[2:0], 1'b0}; c = a[3]; end
      4'd7: begin s = {2'b0, a[3:1]}; c = a[0]; end
      4'd8: begin s = a + 5'd1; c = s[4]; end
      4'd9: s = {1'b0, a - 4'd1};
      4'd10: s = {1'b0, b};
      default: s = 5'd0;
    endcase
    return {s[3:0], (s[3:0] == 4'd0), s[3], c, v};
  endfunction

  always_comb begin
    {ivResultado, ivFlagsAlu} = alu_fn(ovOpcode, ovOperandoA, ovOperandoB);
  end

  // Instruction-level reference model
  logic [3:0] m_r [4];
  logic [3:0] m_flags;
  logic [7:0] m_cnt;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 4'd0;
    m_flags = 4'd0;
    m_cnt   = 8'd0;
  endtask

  task automatic model_exec(input logic [11:0] w, output logic [3:0] opa, output logic [3:0] opb,
                            output logic [3:0] wr, output logic [3:0] fl, output logic err,
                            output logic [7:0] cnt);
    logic [3:0] op;
    logic [7:0] r;
    op  = w[11:8];
    opa = m_r[w[5:4]];
    opb = m_r[w[1:0]];
    err = 1'b0;
    if (op <= 4'd10) begin
      r = alu_fn(op, opa, opb);
      m_r[w[7:6]] = r[7:4];
      m_flags = r[3:0];
    end else if (op == 4'hF) begin
      m_r[w[7:6]] = w[3:0];
    end else begin
      err = 1'b1;
    end
    m_cnt = m_cnt + 8'd1;
    wr  = m_r[w[7:6]];
    fl  = m_flags;
    cnt = m_cnt;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    iRst_n = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;
    model_reset();
  endtask

  // Issue one instruction and follow it through EJECUTA, ESCRIBE and back to IDLE
  task automatic run_instr(input logic [11:0] w, input logic [3:0] e_opa, input logic [3:0] e_opb,
                           input logic [3:0] e_wr, input logic [3:0] e_fl, input logic e_err,
                           input logic [7:0] e_cnt);
    int t;
    t = 0;
    @(negedge iClk);
    while (!oListo && t < 10) begin
      @(negedge iClk);
      t++;
    end
    if (!oListo) chk("listo_timeout", 32'(oListo), 32'd1);
    ivPalabra = w;
    iValido   = 1'b1;
    @(posedge iClk);
    #1;
    ivSelLectura = w[7:6];
    ivPalabra    = 12'($urandom);
    @(negedge iClk);
    chk("opcode", 32'(ovOpcode), 32'(w[11:8]));
    chk("operando_a", 32'(ovOperandoA), 32'(e_opa));
    chk("operando_b", 32'(ovOperandoB), 32'(e_opb));
    chk("listo_ejecuta", 32'(oListo), 32'd0);
    chk("hecho_ejecuta", 32'(oHecho), 32'd0);
    @(negedge iClk);
    iValido = 1'b0;
    chk("hecho_escribe", 32'(oHecho), 32'd1);
    chk("error_escribe", 32'(oError), 32'(e_err));
    chk("lectura_rd", 32'(ovLectura), 32'(e_wr));
    chk("flags", 32'(ovFlags), 32'(e_fl));
    @(negedge iClk);
    chk("hecho_idle", 32'(oHecho), 32'd0);
    chk("error_idle", 32'(oError), 32'd0);
    chk("contador", 32'(ovContador), 32'(e_cnt));
    chk("listo_idle", 32'(oListo), 32'd1);
  endtask

  typedef struct {
    logic [11:0] w;
    logic [3:0]  opa;
    logic [3:0]  opb;
    logic [3:0]  wr;
    logic [3:0]  fl;
    logic        err;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [3:0]  opa, opb, wr, fl;
    logic        err;
    logic [7:0]  cnt;
    logic [11:0] w;
    logic [11:0] ws [3];
    logic        acc;
    int          idx;

    tbl[0] = '{12'hF45, 4'd0, 4'd0, 4'd5, 4'b0000, 1'b0, 8'd1};  // LDI R1,5
    tbl[1] = '{12'hF83, 4'd0, 4'd0, 4'd3, 4'b0000, 1'b0, 8'd2};  // LDI R2,3
    tbl[2] = '{12'h012, 4'd5, 4'd3, 4'd8, 4'b0101, 1'b0, 8'd3};  // ADD R0,R1,R2
    tbl[3] = '{12'h1D1, 4'd5, 4'd5, 4'd0, 4'b1010, 1'b0, 8'd4};  // SUB R3,R1,R1
    tbl[4] = '{12'hC00, 4'd8, 4'd8, 4'd8, 4'b1010, 1'b1, 8'd5};  // reserved

    iRst_n = 1'b0; ivPalabra = 12'd0; iValido = 1'b0; ivSelLectura = 2'd0;
    @(negedge iClk);
    @(negedge iClk);
    chk("rst_listo", 32'(oListo), 32'd1);
    chk("rst_contador", 32'(ovContador), 32'd0);
    chk("rst_flags", 32'(ovFlags), 32'd0);
    chk("rst_opcode", 32'(ovOpcode), 32'd0);
    chk("rst_opa", 32'(ovOperandoA), 32'd0);
    chk("rst_opb", 32'(ovOperandoB), 32'd0);
    chk("rst_hecho", 32'(oHecho), 32'd0);
    chk("rst_error", 32'(oError), 32'd0);
    for (int s = 0; s < 4; s++) begin
      ivSelLectura = 2'(s);
      #1 chk("rst_reg", 32'(ovLectura), 32'd0);
    end
    iRst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 5; i++) begin
      model_exec(tbl[i].w, opa, opb, wr, fl, err, cnt);
      run_instr(tbl[i].w, tbl[i].opa, tbl[i].opb, tbl[i].wr, tbl[i].fl, tbl[i].err, tbl[i].cnt);
    end
    ivSelLectura = 2'd1;
    #1 chk("r1_final", 32'(ovLectura), 32'd5);
    ivSelLectura = 2'd2;
    #1 chk("r2_final", 32'(ovLectura), 32'd3);

    // iValido held high across three words: one acceptance per three cycles
    ws[0] = 12'hF0A; ws[1] = 12'hF4B; ws[2] = 12'hF8C;
    for (int i = 0; i < 3; i++) model_exec(ws[i], opa, opb, wr, fl, err, cnt);
    @(negedge iClk);
    idx = 0;
    ivPalabra = ws[0];
    iValido   = 1'b1;
    for (int c = 0; c < 9; c++) begin
      chk("listo_patron", 32'(oListo), 32'((c % 3) == 0));
      acc = oListo;
      @(posedge iClk);
      #1;
      if (acc) begin
        if (idx < 2) begin
          idx++;
          ivPalabra = ws[idx];
        end else begin
          iValido = 1'b0;
        end
      end
      @(negedge iClk);
    end
    chk("contador_hold", 32'(ovContador), 32'(m_cnt));
    for (int s = 0; s < 3; s++) begin
      ivSelLectura = 2'(s);
      #1 chk("reg_hold", 32'(ovLectura), 32'(m_r[s]));
    end

    for (int i = 0; i < 40; i++) begin
      w = 12'($urandom);
      model_exec(w, opa, opb, wr, fl, err, cnt);
      run_instr(w, opa, opb, wr, fl, err, cnt);
    end

    // Reset during EJECUTA aborts the instruction
    apply_reset();
    model_exec(12'hF45, opa, opb, wr, fl, err, cnt);
    run_instr(12'hF45, opa, opb, wr, fl, err, cnt);
    @(negedge iClk);
    ivPalabra = 12'h011;
    iValido   = 1'b1;
    @(posedge iClk);
    #1 iValido = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    chk("abort_listo", 32'(oListo), 32'd1);
    chk("abort_hecho", 32'(oHecho), 32'd0);
    chk("abort_contador", 32'(ovContador), 32'd0);
    @(negedge iClk);
    iRst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge iClk);
      chk("abort_no_hecho", 32'(oHecho), 32'd0);
    end
    ivSelLectura = 2'd0;
    #1 chk("abort_r0", 32'(ovLectura), 32'd0);
    chk("abort_contador_fin", 32'(ovContador), 32'd0);

    // 256 load-immediates wrap the retirement counter
    for (int i = 0; i < 256; i++) begin
      w = {4'hF, 8'($urandom)};
      model_exec(w, opa, opb, wr, fl, err, cnt);
      run_instr(w, opa, opb, wr, fl, err, cnt);
      if (i == 254) chk("contador_255", 32'(ovContador), 32'd255);
    end
    chk("contador_wrap", 32'(ovContador), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
